// File: rtl/song_sequencer_if.sv
// Bus between the auto-play sequencer and the rest of the piano: mode control,
// song ROM read port and the tone/display outputs.
interface song_sequencer_if #(
  parameter int ADDR_W = 6
);
  logic              en;
  logic              start;
  logic              pause;
  logic [ADDR_W-1:0] rom_addr;
  logic [19:0]       rom_data;
  logic [10:0]       frequency;
  logic [2:0]        note;
  logic              busy;
  logic              done;

  modport master (
    output en, start, pause, rom_data,
    input  rom_addr, frequency, note, busy, done
  );

  modport slave (
    input  en, start, pause, rom_data,
    output rom_addr, frequency, note, busy, done
  );
endinterface

// File: rtl/song_sequencer.sv
// Auto-play controller: walks the song ROM and drives frequency/note for each
// entry's duration, with a fixed silence between notes, pause and abort.
module song_sequencer #(
  parameter int TICK_DIV   = 12_500_000,
  parameter int GAP_CYCLES = 2_500_000,
  parameter int ADDR_W     = 6
) (
  input logic             clk,
  input logic             rst,
  song_sequencer_if.slave bus
);
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [10:0]       freq_q;
  logic [2:0]        note_q;
  logic              busy_q;
  logic              done_q;
  logic [3:0]        beat_cnt;
  logic [TICK_W-1:0] tick_cnt;
  logic [GAP_W-1:0]  gap_cnt;

  logic        rom_eos;
  logic [2:0]  rom_note;
  logic [3:0]  rom_dur;
  logic        unused_rsvd;
  logic [10:0] rom_freq;
  logic        paused;

  assign {rom_eos, rom_note, rom_dur, unused_rsvd, rom_freq} = bus.rom_data;

  // Pause silences the tone immediately; the held frequency comes back on release.
  assign paused = bus.pause && (state == PLAY || state == GAP);

  assign bus.rom_addr  = addr_q;
  assign bus.frequency = paused ? 11'd0 : freq_q;
  assign bus.note      = note_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

  // NOTE: all state is updated with non-blocking assignments so every branch
  // below reads the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      freq_q   <= '0;
      note_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      beat_cnt <= '0;
      tick_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      done_q <= 1'b0;
      if (!bus.en) begin
        state  <= IDLE;
        freq_q <= '0;
        note_q <= '0;
        busy_q <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (bus.start) begin
              addr_q <= '0;
              state  <= FETCH;
              busy_q <= 1'b1;
            end
          end

          FETCH: state <= LOAD;

          LOAD: begin
            if (rom_eos) begin
              state  <= DONE;
              done_q <= 1'b1;
              busy_q <= 1'b0;
            end else if (rom_dur == 4'd0) begin
              if (addr_q == ADDR_LAST) begin
                state  <= DONE;
                done_q <= 1'b1;
                busy_q <= 1'b0;
              end else begin
                addr_q <= addr_q + 1'b1;
                state  <= FETCH;
              end
            end else begin
              freq_q   <= rom_freq;
              note_q   <= rom_note;
              beat_cnt <= rom_dur;
              tick_cnt <= '0;
              state    <= PLAY;
            end
          end

          PLAY: begin
            if (!bus.pause) begin
              if (tick_cnt == TICK_LAST) begin
                tick_cnt <= '0;
                beat_cnt <= beat_cnt - 4'd1;
                if (beat_cnt == 4'd1) begin
                  freq_q <= '0;
                  note_q <= '0;
                  if (GAP_CYCLES > 0) begin
                    gap_cnt <= '0;
                    state   <= GAP;
                  end else if (addr_q == ADDR_LAST) begin
                    state  <= DONE;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                  end else begin
                    addr_q <= addr_q + 1'b1;
                    state  <= FETCH;
                  end
                end
              end else begin
                tick_cnt <= tick_cnt + 1'b1;
              end
            end
          end

          GAP: begin
            if (!bus.pause) begin
              if (gap_cnt == GAP_LAST) begin
                if (addr_q == ADDR_LAST) begin
                  state  <= DONE;
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                end else begin
                  addr_q <= addr_q + 1'b1;
                  state  <= FETCH;
                end
              end else begin
                gap_cnt <= gap_cnt + 1'b1;
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer: a per-cycle expected trace is built
// from the ROM contents when start is driven, then popped and compared each cycle.
module tb_song_sequencer;
  localparam int TICK   = 4;
  localparam int GAPC   = 2;
  localparam int AW     = 3;
  localparam int NWORDS = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          busy;
    logic          done;
    logic [2:0]    note;
    logic [10:0]   freq;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [19:0] rom [NWORDS];
  obs_t exp_q [$];
  int checks = 0;
  int errors = 0;

  song_sequencer_if #(.ADDR_W(AW)) bus ();

  song_sequencer #(
    .TICK_DIV  (TICK),
    .GAP_CYCLES(GAPC),
    .ADDR_W    (AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data valid one cycle after the address.
  always_ff @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [19:0] word(input bit eos, input int nt, input int dur, input int fr);
    return {eos, 3'(nt), 4'(dur), 1'b0, 11'(fr)};
  endfunction

  function automatic obs_t mk(input int a, input bit busy, input bit done, input int nt, input int fr);
    obs_t o;
    o.addr = AW'(a);
    o.busy = busy;
    o.done = done;
    o.note = 3'(nt);
    o.freq = 11'(fr);
    return o;
  endfunction

  function automatic obs_t sample();
    return {bus.rom_addr, bus.busy, bus.done, bus.note, bus.frequency};
  endfunction

  // Expected trace starting with the cycle after start is sampled (FETCH of address 0).
  task automatic build_trace(input int pause_at, input int pause_len);
    int  a = 0;
    bit  first = 1'b1;
    logic [19:0] w;
    forever begin
      w = rom[a];
      exp_q.push_back(mk(a, 1, 0, 0, 0));
      exp_q.push_back(mk(a, 1, 0, 0, 0));
      if (w[19]) begin
        exp_q.push_back(mk(a, 0, 1, 0, 0));
        break;
      end
      if (w[15:12] != 4'd0) begin
        for (int c = 0; c < int'(w[15:12]) * TICK; c++) begin
          if (first && c == pause_at)
            repeat (pause_len) exp_q.push_back(mk(a, 1, 0, int'(w[18:16]), 0));
          exp_q.push_back(mk(a, 1, 0, int'(w[18:16]), int'(w[10:0])));
        end
        first = 1'b0;
        repeat (GAPC) exp_q.push_back(mk(a, 1, 0, 0, 0));
      end
      if (a == NWORDS - 1) begin
        exp_q.push_back(mk(a, 0, 1, 0, 0));
        break;
      end
      a++;
    end
    repeat (2) exp_q.push_back(mk(a, 0, 0, 0, 0));
  endtask

  // Entered and left at 1 time unit after a rising edge. Trace index 0 is the
  // FETCH cycle; the note of address 0 begins at index 2.
  task automatic run(input string name, input int pause_at, input int pause_len,
                     input int start_at, input int abort_at, input int rst_at);
    int   idx = 0;
    obs_t want;
    bus.start = 1'b1;
    build_trace(pause_at, pause_len);
    @(posedge clk); #1;
    while (exp_q.size() > 0) begin
      bus.pause = (pause_at >= 0) && (idx >= 2 + pause_at) && (idx < 2 + pause_at + pause_len);
      bus.start = (idx == start_at);
      bus.en    = !(idx == abort_at);
      rst       = (idx == rst_at);
      @(negedge clk);
      want = exp_q.pop_front();
      check($sformatf("%s[%0d]", name, idx), 32'(sample()), 32'(want));
      if (idx == abort_at || idx == rst_at) begin
        exp_q.delete();
        repeat (3) exp_q.push_back(mk((idx == rst_at) ? 0 : int'(want.addr), 0, 0, 0, 0));
      end
      @(posedge clk); #1;
      idx++;
    end
    bus.pause = 1'b0;
    bus.start = 1'b0;
    bus.en    = 1'b1;
    rst       = 1'b0;
  endtask

  initial begin
    bus.en    = 1'b1;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    foreach (rom[i]) rom[i] = word(1, 0, 0, 0);
    rom[0] = word(0, 1, 2, 262);
    rom[1] = word(0, 2, 1, 294);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset", 32'(sample()), 32'(mk(0, 0, 0, 0, 0)));
    @(posedge clk); #1;

    run("basic",      -1, 0, -1, -1, -1);
    run("pause",       3, 5, -1, -1, -1);
    run("start_gap",  -1, 0, 10, -1, -1);
    run("abort",      -1, 0, -1,  5, -1);
    run("replay",     -1, 0, -1, -1, -1);
    run("rst_play",   -1, 0, -1, -1,  4);

    for (int i = 0; i < NWORDS; i++) rom[i] = word(0, (i % 7) + 1, 1, 100 + 10 * i);
    rom[1] = word(0, 7, 0, 2000);
    run("skip_limit", -1, 0, -1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
